// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// default timeout and small decode helpers.
package mem_access_unit_pkg;

  localparam int DEF_TIMEOUT_CYCLES = 16;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_RESP = 2'b11
  } mau_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for stores and lane select plus
// sign/zero extension for loads.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // funct3[2] marks the unsigned load variants
  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3[1:0])
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        if (i_funct3[2]) begin
          o_rdata = {24'h000000, w_byte};
        end else begin
          o_rdata = {{24{w_byte[7]}}, w_byte};
        end
      end
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        if (i_funct3[2]) begin
          o_rdata = {16'h0000, w_half};
        end else begin
          o_rdata = {{16{w_half[15]}}, w_half};
        end
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit bridging the core to a req/ack memory bus with timeout.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic              st_en,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata_out,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  mau_state_e r_state, w_state_nxt;

  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_misalign, w_misalign_nxt;
  logic              r_bus_err, w_bus_err_nxt;
  logic              r_mem_req, w_req_nxt;
  logic              r_mem_we, w_we_nxt;
  logic [3:0]        r_mem_be, w_be_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
  logic [31:0]       r_mem_wdata, w_wdata_nxt;
  logic [31:0]       r_rdata_out, w_rdata_nxt;
  logic [CNT_W-1:0]  r_wait_cnt, w_cnt_nxt;
  logic              r_is_store, w_is_store_nxt;
  logic [2:0]        r_funct3, w_funct3_nxt;
  logic [1:0]        r_addr_lo, w_addr_lo_nxt;

  logic [2:0]        w_al_funct3;
  logic [1:0]        w_al_addr_lo;
  logic [3:0]        w_al_be;
  logic [31:0]       w_al_wdata;
  logic [31:0]       w_al_rdata;
  logic              w_trap;

`ifdef MISALIGN_TRAP_EN
  assign w_trap = f3_misaligned(funct3, addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  // The single aligner sees live inputs at acceptance and the captured access afterwards
  always_comb begin
    if (r_state == S_IDLE) begin
      w_al_funct3  = funct3;
      w_al_addr_lo = addr[1:0];
    end else begin
      w_al_funct3  = r_funct3;
      w_al_addr_lo = r_addr_lo;
    end
  end

  mem_lane_align u_lane_align (
    .i_funct3  (w_al_funct3),
    .i_addr_lo (w_al_addr_lo),
    .i_wdata   (wdata),
    .i_rdata   (mem_rdata),
    .o_be      (w_al_be),
    .o_wdata   (w_al_wdata),
    .o_rdata   (w_al_rdata)
  );

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_misalign_nxt = 1'b0;
    w_bus_err_nxt  = 1'b0;
    w_req_nxt      = r_mem_req;
    w_we_nxt       = r_mem_we;
    w_be_nxt       = r_mem_be;
    w_addr_nxt     = r_mem_addr;
    w_wdata_nxt    = r_mem_wdata;
    w_rdata_nxt    = r_rdata_out;
    w_cnt_nxt      = r_wait_cnt;
    w_is_store_nxt = r_is_store;
    w_funct3_nxt   = r_funct3;
    w_addr_lo_nxt  = r_addr_lo;
    case (r_state)
      S_IDLE: begin
        if (ld_en || st_en) begin
          w_is_store_nxt = st_en;
          w_funct3_nxt   = funct3;
          w_addr_lo_nxt  = addr[1:0];
          w_addr_nxt     = {addr[ADDR_W-1:2], 2'b00};
          w_cnt_nxt      = '0;
          if (!f3_legal(st_en, funct3)) begin
            w_state_nxt   = S_RESP;
            w_done_nxt    = 1'b1;
            w_bus_err_nxt = 1'b1;
            w_rdata_nxt   = 32'h0000_0000;
          end else if (w_trap) begin
            w_state_nxt    = S_RESP;
            w_done_nxt     = 1'b1;
            w_misalign_nxt = 1'b1;
            w_rdata_nxt    = 32'h0000_0000;
          end else begin
            w_state_nxt = S_REQ;
            w_busy_nxt  = 1'b1;
            w_req_nxt   = 1'b1;
            w_we_nxt    = st_en;
            w_be_nxt    = w_al_be;
            w_wdata_nxt = w_al_wdata;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ, S_WAIT: begin
        if (mem_ack || ((r_state == S_WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)))) begin
          w_state_nxt   = S_RESP;
          w_done_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_req_nxt     = 1'b0;
          w_we_nxt      = 1'b0;
          w_be_nxt      = 4'b0000;
          w_bus_err_nxt = !mem_ack;
          w_rdata_nxt   = (mem_ack && !r_is_store) ? w_al_rdata : 32'h0000_0000;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = (r_state == S_WAIT) ? (r_wait_cnt + CNT_W'(1'b1)) : '0;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and captured access context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b0000;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0000_0000;
      r_rdata_out <= 32'h0000_0000;
      r_wait_cnt  <= '0;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
    end else begin
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_misalign  <= w_misalign_nxt;
      r_bus_err   <= w_bus_err_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_be    <= w_be_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_rdata_out <= w_rdata_nxt;
      r_wait_cnt  <= w_cnt_nxt;
      r_is_store  <= w_is_store_nxt;
      r_funct3    <= w_funct3_nxt;
      r_addr_lo   <= w_addr_lo_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata_out = r_rdata_out;

endmodule
